// File: rtl/traffic_pkg.sv
// traffic_pkg: shared light command codes, lamp encodings and sequencer states.
package traffic_pkg;
  localparam logic [1:0] LIGHT_RED = 2'b00;
  localparam logic [1:0] LIGHT_N   = 2'b01;
  localparam logic [1:0] LIGHT_W   = 2'b10;
  localparam logic [2:0] LAMP_R = 3'b100;
  localparam logic [2:0] LAMP_Y = 3'b010;
  localparam logic [2:0] LAMP_G = 3'b001;
  typedef enum logic [2:0] {IDLE, N_GRN, N_YEL, W_GRN, W_YEL, CLEAR} state_t;
  function automatic logic [2:0] lamp_of(input state_t s, input logic north);
    return (s == (north ? N_GRN : W_GRN)) ? LAMP_G :
           (s == (north ? N_YEL : W_YEL)) ? LAMP_Y : LAMP_R;
  endfunction
endpackage

// File: rtl/cycle_timer.sv
// cycle_timer: 4-bit loadable down-counter that holds at zero and flags it.
module cycle_timer (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic       en,
  input  logic [3:0] load_val,
  output logic       zero
);
  logic [3:0] count_q, count_d;
  always_comb count_d = load ? load_val : (en && count_q != 4'd0) ? count_q - 4'd1 : count_q;
  always_ff @(posedge clk or posedge reset)
    if (reset) count_q <= 4'd0;
    else count_q <= count_d;
  assign zero = (count_q == 4'd0);
endmodule

// File: rtl/lamp_sequencer.sv
// lamp_sequencer: turns north/west go commands into lamp drives with full yellow and clearance phases.
module lamp_sequencer
  import traffic_pkg::*;
#(
  parameter int YEL_CYC = 3,
  parameter int CLR_CYC = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] light,
  output logic [2:0] n_lamp,
  output logic [2:0] w_lamp,
  output logic       busy
);
  localparam logic [3:0] YEL_LD = 4'(YEL_CYC - 1);
  localparam logic [3:0] CLR_LD = 4'(CLR_CYC - 1);
  state_t     state_q, state_d;
  logic [2:0] n_lamp_q, n_lamp_d, w_lamp_q, w_lamp_d;
  logic       busy_q, busy_d, ld, en, zero;
  logic [3:0] ld_val;
  cycle_timer u_timer (.clk(clk), .reset(reset), .load(ld), .en(en), .load_val(ld_val), .zero(zero));
  always_comb begin
    state_d = state_q;
    ld      = 1'b0;
    en      = 1'b0;
    ld_val  = YEL_LD;
    case (state_q)
      IDLE:  state_d = (light == LIGHT_N) ? N_GRN : (light == LIGHT_W) ? W_GRN : IDLE;
      N_GRN: if (light != LIGHT_N) begin state_d = N_YEL; ld = 1'b1; end
      W_GRN: if (light != LIGHT_W) begin state_d = W_YEL; ld = 1'b1; end
      N_YEL, W_YEL: begin
        if (zero) begin state_d = CLEAR; ld = 1'b1; ld_val = CLR_LD; end
        else en = 1'b1;
      end
      CLEAR: if (zero) state_d = IDLE; else en = 1'b1;
      default: state_d = IDLE;
    endcase
    // Outputs are decoded from the next state so the lamps flop in step with the state.
    n_lamp_d = lamp_of(state_d, 1'b1);
    w_lamp_d = lamp_of(state_d, 1'b0);
    busy_d   = (state_d == N_YEL) || (state_d == W_YEL) || (state_d == CLEAR);
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q  <= IDLE;
      n_lamp_q <= LAMP_R;
      w_lamp_q <= LAMP_R;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      n_lamp_q <= n_lamp_d;
      w_lamp_q <= w_lamp_d;
      busy_q   <= busy_d;
    end
  assign n_lamp = n_lamp_q;
  assign w_lamp = w_lamp_q;
  assign busy   = busy_q;
endmodule

// File: tb/tb_lamp_sequencer.sv
// tb_lamp_sequencer: directed stimulus checked every cycle against a queue-based phase model.
module tb_lamp_sequencer;
  localparam int YEL = 3;
  localparam int CLR = 2;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] light = 2'b00;
  logic [2:0] n_lamp, w_lamp;
  logic       busy;
  int checks = 0;
  int errors = 0;
  lamp_sequencer #(.YEL_CYC(YEL), .CLR_CYC(CLR)) dut (
    .clk(clk), .reset(reset), .light(light), .n_lamp(n_lamp), .w_lamp(w_lamp), .busy(busy)
  );
  always #5 clk = ~clk;
  // Model: g is the direction currently green (0 none); q holds the forced yellow/clear/idle tail.
  logic [6:0] q[$];
  logic [6:0] cur;
  int g;
  function automatic logic [6:0] steady(input int d);
    return d == 1 ? {3'b001, 3'b100, 1'b0} : d == 2 ? {3'b100, 3'b001, 1'b0} : {3'b100, 3'b100, 1'b0};
  endfunction
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      q.delete();
      g = 0;
      cur = steady(0);
    end else begin
      if (q.size() == 0 && g != 0 && int'(light) != g) begin
        for (int i = 0; i < YEL; i++) q.push_back(g == 1 ? {3'b010, 3'b100, 1'b1} : {3'b100, 3'b010, 1'b1});
        for (int i = 0; i < CLR; i++) q.push_back({3'b100, 3'b100, 1'b1});
        q.push_back(steady(0));
        g = 0;
      end else if (q.size() == 0 && g == 0)
        g = light == 2'b01 ? 1 : light == 2'b10 ? 2 : 0;
      cur = q.size() != 0 ? q.pop_front() : steady(g);
    end
  end
  task automatic chk(input string name, input logic [6:0] act, input logic [6:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %b, expected %b at %0t", name, act, exp_v, $time);
    end
  endtask
  task automatic cmp_model();
    chk("model_n_lamp", 7'(n_lamp), 7'(cur[6:4]));
    chk("model_w_lamp", 7'(w_lamp), 7'(cur[3:1]));
    chk("model_busy", 7'(busy), 7'(cur[0]));
    chk("n_onehot", 7'($onehot(n_lamp)), 7'd1);
    chk("w_onehot", 7'($onehot(w_lamp)), 7'd1);
    chk("exclusive", 7'(n_lamp != 3'b100 && w_lamp != 3'b100), 7'd0);
  endtask
  task automatic lit(input string name, input logic [2:0] n, input logic [2:0] w, input logic b);
    chk({name, "_n"}, 7'(n_lamp), 7'(n));
    chk({name, "_w"}, 7'(w_lamp), 7'(w));
    chk({name, "_busy"}, 7'(busy), 7'(b));
  endtask
  task automatic tick(input logic [1:0] l);
    light = l;
    @(posedge clk);
    @(negedge clk);
    cmp_model();
  endtask
  initial begin
    repeat (3) tick(2'b01);
    lit("reset_held", 3'b100, 3'b100, 1'b0);
    reset = 1'b0;
    repeat (4) begin tick(2'b00); lit("idle_red", 3'b100, 3'b100, 1'b0); end
    tick(2'b01); lit("n_go", 3'b001, 3'b100, 1'b0);
    repeat (3) begin tick(2'b00); lit("n_yel", 3'b010, 3'b100, 1'b1); end
    repeat (2) begin tick(2'b00); lit("n_clr", 3'b100, 3'b100, 1'b1); end
    tick(2'b00); lit("n_done", 3'b100, 3'b100, 1'b0);
    tick(2'b01); tick(2'b01); lit("n_hold", 3'b001, 3'b100, 1'b0);
    repeat (3) begin tick(2'b10); lit("dir_yel", 3'b010, 3'b100, 1'b1); end
    repeat (2) begin tick(2'b10); lit("dir_clr", 3'b100, 3'b100, 1'b1); end
    tick(2'b10); lit("dir_idle", 3'b100, 3'b100, 1'b0);
    tick(2'b10); lit("w_after6", 3'b100, 3'b001, 1'b0);
    repeat (6) tick(2'b00);
    lit("w_done", 3'b100, 3'b100, 1'b0);
    tick(2'b01);
    tick(2'b00); lit("ret_yel1", 3'b010, 3'b100, 1'b1);
    repeat (2) begin tick(2'b01); lit("ret_yel", 3'b010, 3'b100, 1'b1); end
    repeat (2) begin tick(2'b01); lit("ret_clr", 3'b100, 3'b100, 1'b1); end
    tick(2'b01); lit("ret_idle", 3'b100, 3'b100, 1'b0);
    tick(2'b01); lit("ret_green", 3'b001, 3'b100, 1'b0);
    repeat (6) tick(2'b00);
    repeat (3) begin tick(2'b11); lit("rsv_idle", 3'b100, 3'b100, 1'b0); end
    tick(2'b10); lit("w_go", 3'b100, 3'b001, 1'b0);
    tick(2'b11); lit("rsv_wyel", 3'b100, 3'b010, 1'b1);
    repeat (2) tick(2'b11);
    lit("rsv_wyel3", 3'b100, 3'b010, 1'b1);
    repeat (2) begin tick(2'b11); lit("rsv_clr", 3'b100, 3'b100, 1'b1); end
    tick(2'b11); lit("rsv_end", 3'b100, 3'b100, 1'b0);
    tick(2'b11); lit("rsv_stay", 3'b100, 3'b100, 1'b0);
    tick(2'b01);
    tick(2'b00);
    tick(2'b00); lit("pre_rst", 3'b010, 3'b100, 1'b1);
    #2 reset = 1'b1;
    #1 lit("async_rst", 3'b100, 3'b100, 1'b0);
    @(negedge clk);
    tick(2'b01); lit("rst_hold", 3'b100, 3'b100, 1'b0);
    reset = 1'b0;
    tick(2'b01); lit("post_rst", 3'b001, 3'b100, 1'b0);
    #2 reset = 1'b1;
    #1 lit("green_rst", 3'b100, 3'b100, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    tick(2'b00); lit("green_rst_idle", 3'b100, 3'b100, 1'b0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/lamp_sequencer.md
LAMP_SEQUENCER -- requirements
Module: lamp_sequencer

Interface
REQ-001 Parameter YEL_CYC, default 3: number of clk cycles a yellow phase lasts; legal range 1..15.
REQ-002 Parameter CLR_CYC, default 2: number of all-red clearance cycles after each yellow; legal range 1..15.
REQ-003 clk  input  1  single clock; all state changes on the rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 light  input  2  phase command from the upstream fsm: 2'b00 all red, 2'b01 north go, 2'b10 west go, 2'b11 reserved.
REQ-006 n_lamp  output  3  north lamp drive, one-hot {red, yellow, green}, registered.
REQ-007 w_lamp  output  3  west lamp drive, one-hot {red, yellow, green}, registered.
REQ-008 busy  output  1  high while in any yellow or clearance state; registered.

Function
REQ-009 States SHALL be IDLE (all red), N_GRN, N_YEL, W_GRN, W_YEL, CLEAR.
REQ-010 IDLE: light==01 -> N_GRN; light==10 -> W_GRN; light==00 or 11 -> stay IDLE.
REQ-011 N_GRN: stay while light==01; any other value -> N_YEL, timer loaded YEL_CYC-1.
REQ-012 W_GRN: stay while light==10; any other value -> W_YEL, timer loaded YEL_CYC-1.
REQ-013 N_YEL / W_YEL: timer decrements each cycle; at timer==0 -> CLEAR, timer loaded CLR_CYC-1.
REQ-014 CLEAR: timer decrements; at timer==0 -> IDLE.
REQ-015 Yellow and clearance phases SHALL complete in full regardless of light during them; light is not latched and is only sampled in IDLE and the green states.
REQ-016 A direction change (01 -> 10 directly) SHALL pass through yellow and CLEAR before the other green.
REQ-017 Latency: light change sampled in IDLE -> green lamp visible on the output one cycle later.
REQ-018 Green -> green of the other direction: SHALL take exactly 1 + YEL_CYC + CLR_CYC + 1 cycles from the first edge sampling the new command, provided the command is held.
REQ-019 Lamp decode: IDLE/CLEAR both red; N_GRN n=green, w=red; N_YEL n=yellow, w=red; mirror for west.
REQ-020 Invariant: n_lamp and w_lamp SHALL never both be non-red in the same cycle; each lamp vector SHALL always be exactly one-hot.
REQ-021 Reserved 11 SHALL be treated as 00 (ends green via yellow, never starts one).
REQ-022 busy SHALL be 1 exactly in N_YEL, W_YEL and CLEAR.

Reset
REQ-023 reset SHALL asynchronously force state IDLE, timer 0, n_lamp=100, w_lamp=100, busy=0.
REQ-024 Reset asserted mid-yellow or mid-green SHALL drive both lamps red immediately, with no yellow phase.
REQ-025 After reset deassertion the first light sample SHALL occur on the next rising edge.

Structure
REQ-026 Shared package traffic_pkg SHALL hold the light codes (LIGHT_RED, LIGHT_N, LIGHT_W), lamp one-hot constants (LAMP_R, LAMP_Y, LAMP_G) and the state encoding.
REQ-027 The down-counter SHALL be a sub-module cycle_timer (4-bit, load/enable, zero flag) instantiated once.
REQ-028 All outputs SHALL be flop outputs; no combinational path from light to any output.

Verification
REQ-029 Reset held 3 cycles, then light=00 for 4 cycles -> n_lamp=w_lamp=100 and busy=0 throughout.
REQ-030 light=01 sampled in IDLE -> n_lamp=001 next cycle; light=00 -> n_lamp=010 for 3 cycles, then 100 for 2 cycles (busy=1 for those 5), then IDLE.
REQ-031 light 01 -> 10 directly -> north yellow 3 cycles, all red 2 cycles, then w_lamp=001 (6 cycles after the change is sampled).
REQ-032 light returns to 01 during N_YEL -> yellow and clear still complete; n_lamp=001 again 1 cycle after returning to IDLE.
REQ-033 light=11 from IDLE -> stays all red; light=11 during W_GRN -> W_YEL sequence as for 00.
REQ-034 reset pulsed during N_YEL -> lamps 100/100 within the same cycle, busy=0; continuous assertion checks one-hot lamps and the REQ-020 invariant on every cycle.
